// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit and its register file.
// Contents:
//   - FSM state encoding: IDLE, EXEC, DONE (2 bits).
//   - ALU opcode constants OP_ADD..OP_ABS (0..7). The ALU bench uses the same values.
//   - Register-index width.
package alu_issue_unit_pkg;

  localparam int REG_IDX_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_ABS = 3'd7;

endpackage

// File: rtl/alu_issue_unit_regfile.sv
// alu_regfile: a 4 x N operand register file.
// It has two synchronous write ports and three combinational read ports.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset (all registers go to 0)
//   wb_en_i/addr/data   write port 0, the ALU writeback; it has priority
//   ld_en_i/addr/data   write port 1, the external load
//   rs1/rs2/rd_addr_i   read indices
//   rs1/rs2/rd_data_o   combinational read data
module alu_regfile
  import alu_issue_unit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_en_i,
  input  logic [REG_IDX_W-1:0] wb_addr_i,
  input  logic [N-1:0]         wb_data_i,
  input  logic                 ld_en_i,
  input  logic [REG_IDX_W-1:0] ld_addr_i,
  input  logic [N-1:0]         ld_data_i,
  input  logic [REG_IDX_W-1:0] rs1_addr_i,
  input  logic [REG_IDX_W-1:0] rs2_addr_i,
  input  logic [REG_IDX_W-1:0] rd_addr_i,
  output logic [N-1:0]         rs1_data_o,
  output logic [N-1:0]         rs2_data_o,
  output logic [N-1:0]         rd_data_o
);

  logic [N-1:0] regs_q [4];
  logic         ld_blocked;

  // The load to a register is dropped when the writeback targets the same register.
  assign ld_blocked = wb_en_i && (wb_addr_i == ld_addr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      if (wb_en_i) regs_q[wb_addr_i] <= wb_data_i;
      if (ld_en_i && !ld_blocked) regs_q[ld_addr_i] <= ld_data_i;
    end
  end

  assign rs1_data_o = regs_q[rs1_addr_i];
  assign rs2_data_o = regs_q[rs2_addr_i];
  assign rd_data_o  = regs_q[rd_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: sequential front end for the combinational 8-opcode ALU.
// It accepts register-addressed instructions and drives registered A, B and opcode to the ALU.
// It then writes the ALU result back to R[rd] and latches the ALU flags.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready are both 1.
// instr_ready is 1 only in IDLE. The source holds the instr_* fields stable until the transfer.
// instr_valid outside IDLE has no effect.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   instr_valid/instr_ready     instruction handshake
//   instr_opcode/rd/rs1/rs2     instruction fields
//   load_en/load_addr/load_data external register write; honoured in every state
//   rd_addr/rd_data             combinational observation read
//   alu_A/alu_B/alu_opcode      registered ALU inputs; held until the next accept
//   alu_result/alu_flags        ALU outputs; alu_flags is {carry, zero}
//   flags_q                     flags latched at the last writeback
//   done                        high in the cycle after writeback
//   dbg_state                   current FSM state, for observation
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [2:0]           instr_opcode,
  input  logic [REG_IDX_W-1:0] instr_rd,
  input  logic [REG_IDX_W-1:0] instr_rs1,
  input  logic [REG_IDX_W-1:0] instr_rs2,
  input  logic                 load_en,
  input  logic [REG_IDX_W-1:0] load_addr,
  input  logic [N-1:0]         load_data,
  input  logic [REG_IDX_W-1:0] rd_addr,
  output logic [N-1:0]         rd_data,
  output logic [N-1:0]         alu_A,
  output logic [N-1:0]         alu_B,
  output logic [2:0]           alu_opcode,
  input  logic [N-1:0]         alu_result,
  input  logic [1:0]           alu_flags,
  output logic [1:0]           flags_q,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  logic [1:0]           state_q, state_d;
  logic [N-1:0]         alu_a_q, alu_b_q;
  logic [2:0]           opcode_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [N-1:0]         rs1_data, rs2_data;
  logic                 accept;
  logic                 wb_en;

  assign accept = (state_q == ST_IDLE) && instr_valid;
  assign wb_en  = (state_q == ST_EXEC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are captured from the pre-edge register contents.
  // A load in the same cycle therefore does not reach the captured operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      opcode_q <= '0;
      rd_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q  <= rs1_data;
        alu_b_q  <= rs2_data;
        opcode_q <= instr_opcode;
        rd_q     <= instr_rd;
      end
      if (wb_en) flags_q <= alu_flags;
    end
  end

  alu_regfile #(.N(N)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_en_i    (wb_en),
    .wb_addr_i  (rd_q),
    .wb_data_i  (alu_result),
    .ld_en_i    (load_en),
    .ld_addr_i  (load_addr),
    .ld_data_i  (load_data),
    .rs1_addr_i (instr_rs1),
    .rs2_addr_i (instr_rs2),
    .rd_addr_i  (rd_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .rd_data_o  (rd_data)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_opcode  = opcode_q;
  assign dbg_state   = state_q;

endmodule
